pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Parametrised fetch-address generator at the head of the fetch stage, replacing the single-issue PC register. Emits one fetch-group address per cycle, FETCH_WIDTH instructions wide, under a valid/ready handshake with instruction memory. Takes redirects from execute (branch resolve) and decode (prediction), with fixed priority. Tags each group with a redirect epoch so downstream stages can drop stale groups.

Parameters:
ADDR, 32, instruction address width (word-addressed, one instruction per address)
FETCH_WIDTH, 2, instructions per fetch group; power of two, 1..8
RESET_PC, 0, first fetch address after reset
EPOCH_W, 2, epoch counter width
RAS_DEPTH, 4, return-address-stack entries; power of two; used only with PC_GEN_RAS_EN

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
pc_ready_i  in  1  fetch consumer accepts current group
pc_valid_o  out  1  pc_o/lane_mask_o/epoch_o valid
pc_o  out  ADDR  address of first valid lane of current group
lane_mask_o  out  FETCH_WIDTH  bit k set = lane k (aligned base + k) valid
epoch_o  out  EPOCH_W  epoch tag of current group
branch_i  in  1  execute redirect (misprediction)
branch_addr_i  in  ADDR  execute redirect target
pred_i  in  1  decode predicted-taken redirect
pred_addr_i  in  ADDR  predicted target
call_i  in  1  decode saw a call (RAS push); ignored without macro
call_ret_addr_i  in  ADDR  return address to push
ret_i  in  1  decode saw a return (RAS-predicted redirect); ignored without macro
ras_empty_o  out  1  RAS holds no entries; constant 1 without macro

Behaviour:
- One clock domain. Reset is asynchronous and active-low, on clk/reset.
- Reset values: state BOOT, pc_valid_o 0, pc_o RESET_PC, lane_mask_o from RESET_PC alignment, epoch_o 0, RAS count 0, ras_empty_o 1.
- FSM with states BOOT and RUN. BOOT lasts exactly one cycle after reset deasserts, with pc_valid_o 0, then moves to RUN. In RUN, pc_valid_o is 1 every cycle.
- Reset asserted mid-operation returns to BOOT at once and discards pending redirects.
- Alignment: base = pc with its low log2(FETCH_WIDTH) bits cleared. lane_mask_o sets bits offset..FETCH_WIDTH-1, where offset = pc mod FETCH_WIDTH.
- Next-PC priority, evaluated each RUN cycle, registered with 1-cycle latency:
  1. branch_i → branch_addr_i
  2. ret_i (macro only) → RAS top
  3. pred_i → pred_addr_i
  4. pc_valid_o & pc_ready_i → base + FETCH_WIDTH
  5. otherwise hold; all outputs stable while ready is low.
- A redirect applies regardless of pc_ready_i. The current group is superseded, not handed over.
- Redirects in BOOT are ignored.
- Each applied redirect (1–3) increments epoch_o by 1, modulo 2^EPOCH_W; wrap is silent. Sequential advance and hold do not change the epoch.
- Sequential increment wraps modulo 2^ADDR.
- Simultaneous branch_i and pred_i: branch wins, epoch increments once, pred dropped.

Optional Feature:
Macro PC_GEN_RAS_EN.
- Defined:
  - Circular return-address stack of RAS_DEPTH entries and a count 0..RAS_DEPTH.
  - call_i pushes call_ret_addr_i. When full, the oldest entry is overwritten and count saturates.
  - ret_i pops and redirects to the top entry. Pop when empty redirects to RESET_PC and count stays 0.
  - call_i and ret_i in the same cycle: redirect to the old top, then replace the top with call_ret_addr_i; count unchanged.
  - call_i/ret_i are ignored when branch_i is high, and the RAS is left unchanged by branch flushes.
- Undefined: no RAS storage, call_i/ret_i ignored, ras_empty_o tied 1.

Decomposition:
- Shared package/include: state encoding (BOOT, RUN), the alignment-offset helper function, default RESET_PC.
- One sub-module, pc_ras: the stack storage, pointer and count. Instantiated only under PC_GEN_RAS_EN.

Test Plan:
- Reset: RESET_PC=0, FW=2, reset released → pc_valid_o 0 for 1 cycle, then pc_o=0, mask=2'b11, epoch 0.
- Stall/advance: ready low 3 cycles → pc_o held at 0x4. Ready high → 0x6, then 0x8.
- Unaligned redirect: pred_i with target 0x13, FW=4 → next cycle pc_o=0x13, mask=4'b1000, epoch+1. After accept → pc_o=0x14, mask=4'b1111.
- Priority: branch_i (0x40) and pred_i (0x80) in the same cycle → pc_o=0x40, epoch incremented by exactly 1. With EPOCH_W=2, four redirects → epoch back to 0.
- RAS (macro on, depth 4): 5 pushes (A..E), then 5 returns → targets E, D, C, B, then RESET_PC; ras_empty_o rises after the 4th pop.
- Reset mid-stall with a pending branch → BOOT, then pc_o=RESET_PC, epoch 0, branch target discarded.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the fetch-address generator.
//   state_e         BOOT/RUN state encoding
//   DefaultResetPc  default first fetch address
//   align_offset    lane offset of a PC inside its fetch group
//   lane_mask       valid-lane mask for a given offset and group width
// Optional feature macro used by the block: PC_GEN_RAS_EN.
package pc_gen_pkg;

  typedef enum logic [0:0] {
    StBoot,
    StRun
  } state_e;

  localparam int unsigned DefaultResetPc = 0;

  // Fetch groups are at most 8 wide, so only the low three PC bits matter.
  function automatic logic [2:0] align_offset(input logic [2:0] pc_low,
                                              input int unsigned fetch_width);
    return pc_low & 3'(fetch_width - 1);
  endfunction

  // Bits offset..fetch_width-1 set; bits at or above fetch_width are zero.
  function automatic logic [7:0] lane_mask(input logic [2:0] offset,
                                           input int unsigned fetch_width);
    logic [7:0] mask;
    mask = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      mask[k] = (k < fetch_width) && (k >= 32'(offset));
    end
    return mask;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   push_i           push push_addr_i (overwrites the oldest entry when full)
//   push_addr_i      return address to push
//   pop_i            pop the top entry (no-op on the stack when empty)
//   top_o            current top entry, RESET_PC when empty
//   empty_o          stack holds no entries
// push_i and pop_i together replace the top entry and leave the count unchanged.
module pc_ras #(
  parameter int unsigned       ADDR     = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic [ADDR-1:0] push_addr_i,
  input  logic            pop_i,
  output logic [ADDR-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] ptr_q;  // next free slot
  logic [CntW-1:0] cnt_q;
  logic [PtrW-1:0] top_idx;
  logic [PtrW-1:0] ptr_inc;

  always_comb begin
    top_idx = (ptr_q == '0) ? PtrW'(DEPTH - 1) : ptr_q - PtrW'(1);
    ptr_inc = (ptr_q == PtrW'(DEPTH - 1)) ? '0 : ptr_q + PtrW'(1);
  end

  assign empty_o = (cnt_q == '0);
  assign top_o   = empty_o ? RESET_PC : mem_q[top_idx];

  // Storage needs no reset: entries are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (push_i) begin
      if (pop_i) begin
        if (!empty_o) mem_q[top_idx] <= push_addr_i;
      end else begin
        mem_q[ptr_q] <= push_addr_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push_i && !pop_i) begin
      ptr_q <= ptr_inc;
      if (cnt_q != CntW'(DEPTH)) cnt_q <= cnt_q + CntW'(1);
    end else if (pop_i && !push_i && !empty_o) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-group address generator with redirect epochs.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   pc_ready_i        consumer accepts the current group
//   pc_valid_o        pc_o/lane_mask_o/epoch_o valid
//   pc_o              address of the first valid lane
//   lane_mask_o       bit k set = lane (aligned base + k) valid
//   epoch_o           redirect epoch of the current group
//   branch_i/_addr_i  execute redirect (highest priority)
//   pred_i/_addr_i    decode predicted-taken redirect
//   call_i, call_ret_addr_i, ret_i   return-address stack controls
//   ras_empty_o       return-address stack empty
// Macro PC_GEN_RAS_EN enables the return-address stack; without it call_i/ret_i
// are ignored and ras_empty_o is tied high.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     ADDR        = 32,
  parameter int unsigned     FETCH_WIDTH = 2,
  parameter logic [ADDR-1:0] RESET_PC    = ADDR'(DefaultResetPc),
  parameter int unsigned     EPOCH_W     = 2,
  parameter int unsigned     RAS_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pc_ready_i,
  output logic                   pc_valid_o,
  output logic [ADDR-1:0]        pc_o,
  output logic [FETCH_WIDTH-1:0] lane_mask_o,
  output logic [EPOCH_W-1:0]     epoch_o,
  input  logic                   branch_i,
  input  logic [ADDR-1:0]        branch_addr_i,
  input  logic                   pred_i,
  input  logic [ADDR-1:0]        pred_addr_i,
  input  logic                   call_i,
  input  logic [ADDR-1:0]        call_ret_addr_i,
  input  logic                   ret_i,
  output logic                   ras_empty_o
);

  localparam logic [ADDR-1:0] LaneBits = ADDR'(FETCH_WIDTH - 1);

  state_e              state_q;
  logic                valid_q;
  logic [ADDR-1:0]     pc_q;
  logic [EPOCH_W-1:0]  epoch_q;

  logic [ADDR-1:0]     base;
  logic [7:0]          lane_bits;
  logic                run;
  logic                redirect;
  logic [ADDR-1:0]     redirect_pc;
  logic                ras_redirect;
  logic [ADDR-1:0]     ras_top;

  assign run       = (state_q == StRun);
  assign base      = pc_q & ~LaneBits;
  assign lane_bits = lane_mask(align_offset(pc_q[2:0], FETCH_WIDTH), FETCH_WIDTH);

  assign pc_valid_o  = valid_q;
  assign pc_o        = pc_q;
  assign epoch_o     = epoch_q;
  assign lane_mask_o = FETCH_WIDTH'(lane_bits);

`ifdef PC_GEN_RAS_EN
  logic ras_push;
  logic ras_pop;

  // A branch flush masks the stack entirely; BOOT never touches it.
  assign ras_push     = run && call_i && !branch_i;
  assign ras_pop      = run && ret_i && !branch_i;
  assign ras_redirect = ret_i;

  pc_ras #(
    .ADDR     (ADDR),
    .DEPTH    (RAS_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_pc_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ras_push),
    .push_addr_i (call_ret_addr_i),
    .pop_i       (ras_pop),
    .top_o       (ras_top),
    .empty_o     (ras_empty_o)
  );
`else
  logic unused_ras;

  assign unused_ras   = ^{call_i, call_ret_addr_i, ret_i, RAS_DEPTH};
  assign ras_redirect = 1'b0;
  assign ras_top      = RESET_PC;
  assign ras_empty_o  = 1'b1;
`endif

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = pc_q;
    if (branch_i) begin
      redirect    = 1'b1;
      redirect_pc = branch_addr_i;
    end else if (ras_redirect) begin
      redirect    = 1'b1;
      redirect_pc = ras_top;
    end else if (pred_i) begin
      redirect    = 1'b1;
      redirect_pc = pred_addr_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StBoot;
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      epoch_q <= '0;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q <= StRun;
          valid_q <= 1'b1;
        end
        StRun: begin
          // A redirect supersedes the current group whether or not it was taken.
          if (redirect) begin
            pc_q    <= redirect_pc;
            epoch_q <= epoch_q + EPOCH_W'(1);
          end else if (pc_ready_i) begin
            pc_q <= base + ADDR'(FETCH_WIDTH);
          end
        end
        default: begin
          state_q <= StBoot;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk;
  logic        reset;

  // Instance A: FETCH_WIDTH 2
  logic        a_ready, a_branch, a_pred, a_call, a_ret;
  logic [31:0] a_baddr, a_paddr, a_caddr;
  logic        a_valid, a_empty;
  logic [31:0] a_pc;
  logic [1:0]  a_mask;
  logic [1:0]  a_epoch;

  // Instance B: FETCH_WIDTH 4
  logic        b_ready, b_pred;
  logic [31:0] b_paddr;
  logic        b_valid, b_empty;
  logic [31:0] b_pc;
  logic [3:0]  b_mask;
  logic [1:0]  b_epoch;

  pc_gen #(
    .ADDR        (32),
    .FETCH_WIDTH (2),
    .RESET_PC    (32'h0),
    .EPOCH_W     (2),
    .RAS_DEPTH   (4)
  ) dut_a (
    .clk             (clk),
    .reset           (reset),
    .pc_ready_i      (a_ready),
    .pc_valid_o      (a_valid),
    .pc_o            (a_pc),
    .lane_mask_o     (a_mask),
    .epoch_o         (a_epoch),
    .branch_i        (a_branch),
    .branch_addr_i   (a_baddr),
    .pred_i          (a_pred),
    .pred_addr_i     (a_paddr),
    .call_i          (a_call),
    .call_ret_addr_i (a_caddr),
    .ret_i           (a_ret),
    .ras_empty_o     (a_empty)
  );

  pc_gen #(
    .ADDR        (32),
    .FETCH_WIDTH (4),
    .RESET_PC    (32'h0),
    .EPOCH_W     (2),
    .RAS_DEPTH   (4)
  ) dut_b (
    .clk             (clk),
    .reset           (reset),
    .pc_ready_i      (b_ready),
    .pc_valid_o      (b_valid),
    .pc_o            (b_pc),
    .lane_mask_o     (b_mask),
    .epoch_o         (b_epoch),
    .branch_i        (1'b0),
    .branch_addr_i   (32'h0),
    .pred_i          (b_pred),
    .pred_addr_i     (b_paddr),
    .call_i          (1'b0),
    .call_ret_addr_i (32'h0),
    .ret_i           (1'b0),
    .ras_empty_o     (b_empty)
  );

  typedef struct {
    string       tag;
    bit          sel_b;
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  mask;
    logic [1:0]  epoch;
    logic        empty;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  logic [31:0] ret_tgt [5];
  logic        ret_empty [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input bit sel_b, input logic v,
                            input logic [31:0] pc, input logic [3:0] m,
                            input logic [1:0] e, input logic emp);
    exp_t x;
    x.tag = tag; x.sel_b = sel_b; x.valid = v; x.pc = pc;
    x.mask = m; x.epoch = e; x.empty = emp;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t        x;
    logic [39:0] obs;
    logic [39:0] req;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      obs = x.sel_b ? {b_valid, b_pc, b_mask, b_epoch, b_empty}
                    : {a_valid, a_pc, 2'b00, a_mask, a_epoch, a_empty};
      req = {x.valid, x.pc, x.mask, x.epoch, x.empty};
      checks++;
      assert (obs === req)
      else begin
        fails++;
        $error("FAIL %s: got v=%b pc=%h mask=%b ep=%0d empty=%b, want v=%b pc=%h mask=%b ep=%0d empty=%b",
               x.tag, obs[39], obs[38:7], obs[6:3], obs[2:1], obs[0],
               req[39], req[38:7], req[6:3], req[2:1], req[0]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    reset = 1'b1;
    a_ready = 0; a_branch = 0; a_pred = 0; a_call = 0; a_ret = 0;
    a_baddr = '0; a_paddr = '0; a_caddr = '0;
    b_ready = 0; b_pred = 0; b_paddr = '0;
    ret_tgt   = '{32'h104, 32'h103, 32'h102, 32'h101, 32'h0};
    ret_empty = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    #2 reset = 1'b0;
    #10;
    expect_out("rst_a", 0, 0, 32'h0, 4'b0011, 2'd0, 1);
    expect_out("rst_b", 1, 0, 32'h0, 4'b1111, 2'd0, 1);
    drain();

    @(negedge clk) reset = 1'b1;
    #1;
    expect_out("boot_a", 0, 0, 32'h0, 4'b0011, 2'd0, 1);
    drain();
    expect_out("run0_a", 0, 1, 32'h0, 4'b0011, 2'd0, 1);
    expect_out("run0_b", 1, 1, 32'h0, 4'b1111, 2'd0, 1);
    tick();

    // Sequential advance, stall, resume.
    a_ready = 1;
    expect_out("adv2", 0, 1, 32'h2, 4'b0011, 2'd0, 1); tick();
    expect_out("adv4", 0, 1, 32'h4, 4'b0011, 2'd0, 1); tick();
    a_ready = 0;
    for (int i = 0; i < 3; i++) begin
      expect_out("stall4", 0, 1, 32'h4, 4'b0011, 2'd0, 1); tick();
    end
    a_ready = 1;
    expect_out("adv6", 0, 1, 32'h6, 4'b0011, 2'd0, 1); tick();
    expect_out("adv8", 0, 1, 32'h8, 4'b0011, 2'd0, 1); tick();

    // Address wrap at the top of the space.
    a_pred = 1; a_paddr = 32'hFFFF_FFFE;
    expect_out("pred_top", 0, 1, 32'hFFFF_FFFE, 4'b0011, 2'd1, 1); tick();
    a_pred = 0;
    expect_out("addr_wrap", 0, 1, 32'h0, 4'b0011, 2'd1, 1); tick();

    // Unaligned redirect target.
    a_pred = 1; a_paddr = 32'h13;
    expect_out("unal_a", 0, 1, 32'h13, 4'b0010, 2'd2, 1); tick();
    a_pred = 0;
    expect_out("unal_acc", 0, 1, 32'h14, 4'b0011, 2'd2, 1); tick();

    // Branch beats prediction, one epoch step.
    a_branch = 1; a_baddr = 32'h40; a_pred = 1; a_paddr = 32'h80;
    expect_out("prio", 0, 1, 32'h40, 4'b0011, 2'd3, 1); tick();
    a_branch = 0; a_pred = 0; a_ready = 0;

    // Redirect while stalled; fourth redirect wraps the epoch.
    a_branch = 1; a_baddr = 32'h21;
    expect_out("br_stall", 0, 1, 32'h21, 4'b0010, 2'd0, 1); tick();
    a_branch = 0;
    expect_out("hold_after", 0, 1, 32'h21, 4'b0010, 2'd0, 1); tick();

`ifndef PC_GEN_RAS_EN
    a_ret = 1; a_call = 1; a_caddr = 32'h77;
    expect_out("ret_ignored", 0, 1, 32'h21, 4'b0010, 2'd0, 1); tick();
    a_ret = 0; a_call = 0;
`else
    for (int i = 0; i < 5; i++) begin
      a_call = 1; a_caddr = 32'h100 + i;
      expect_out("push", 0, 1, 32'h21, 4'b0010, 2'd0, 0); tick();
    end
    a_call = 0;
    a_ret = 1;
    for (int i = 0; i < 5; i++) begin
      expect_out("ret_pop", 0, 1, ret_tgt[i], ret_tgt[i][0] ? 4'b0010 : 4'b0011,
                 2'(i + 1), ret_empty[i]);
      tick();
    end
    a_ret = 0;
`endif

    // FETCH_WIDTH 4 unaligned redirect.
    b_pred = 1; b_paddr = 32'h13;
    expect_out("b_unal", 1, 1, 32'h13, 4'b1000, 2'd1, 1); tick();
    b_pred = 0; b_ready = 1;
    expect_out("b_acc", 1, 1, 32'h14, 4'b1111, 2'd1, 1); tick();
    expect_out("b_next", 1, 1, 32'h18, 4'b1111, 2'd1, 1); tick();
    b_ready = 0;

    // Reset mid-stall with a pending branch; branch also held through BOOT.
    a_ready = 0; a_branch = 1; a_baddr = 32'h55;
    @(negedge clk) reset = 1'b0;
    #1;
    expect_out("rst_mid_a", 0, 0, 32'h0, 4'b0011, 2'd0, 1);
    expect_out("rst_mid_b", 1, 0, 32'h0, 4'b1111, 2'd0, 1);
    drain();
    @(negedge clk) reset = 1'b1;
    #1;
    expect_out("boot2", 0, 0, 32'h0, 4'b0011, 2'd0, 1);
    drain();
    expect_out("boot_ignore", 0, 1, 32'h0, 4'b0011, 2'd0, 1); tick();
    a_branch = 0;
    expect_out("post_rst", 0, 1, 32'h0, 4'b0011, 2'd0, 1); tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
